instruction_fetch_sequencer: RTL

- Front-end controller that sequences the RV32I instruction decoder.
- Generates in-order instruction-memory fetch requests and tracks outstanding requests.
- Buffers returned words in a small FIFO and presents one instruction plus its PC to the decoder under a valid/ready handshake.
- Handles redirects from branch/jump resolution by flushing wrong-path words, and handles fetch pause.

---
 rtl/instruction_fetch_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/instruction_fetch_sequencer.sv
// instruction_fetch_sequencer
// Front-end controller for the RV32I decoder. Issues in-order word fetches,
// tracks outstanding requests against a credit limit, buffers returned words
// in a small show-ahead FIFO and hands one instruction plus its PC to the
// decoder under a valid/ready handshake. Redirects flush the buffer and mark
// every still-outstanding response as wrong-path so it is dropped on arrival.
//
// Ports:
//   clk               rising-edge clock
//   reset             synchronous, active-low reset
//   fetch_enable      1 = new fetch requests may be issued
//   imem_req_valid    fetch request valid
//   imem_req_ready    memory accepts the request this cycle
//   imem_req_addr     word-aligned fetch address
//   imem_resp_valid   response word valid (in order, never backpressured)
//   imem_resp_data    fetched instruction word
//   redirect_valid    one-cycle redirect pulse
//   redirect_pc       redirect target (bits [1:0] ignored)
//   instruction       buffer head word
//   instruction_pc    PC of the buffer head word
//   instruction_valid buffer head is valid
//   decode_ready      decoder consumes the head this cycle
//   fetch_idle        no outstanding requests and buffer empty (registered)
module instruction_fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IBUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_enable,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instruction,
  output logic [31:0] instruction_pc,
  output logic        instruction_valid,
  input  logic        decode_ready,
  output logic        fetch_idle
);

  localparam int AW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(IBUF_DEPTH);

  typedef enum logic [1:0] {BOOT, RUN, PAUSE} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic            idle_q, idle_d;
  logic [31:0]     instr_mem_q [IBUF_DEPTH];
  logic [31:0]     pc_mem_q    [IBUF_DEPTH];

  logic            credit_ok;
  logic            req_valid;
  logic            req_fire;
  logic            resp_take;
  logic            resp_keep;
  logic            pop;
  logic [31:0]     redirect_target;
  logic            unused_redirect_lsb;

  assign redirect_target     = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Credit covers both in-flight requests and buffered words, so a response
  // always finds a free slot. Words awaiting a drop still hold credit.
  assign credit_ok = ({1'b0, outstanding_q} + {1'b0, count_q}) < DEPTH_W;
  assign req_valid = (state_q == RUN) && credit_ok && !redirect_valid;
  assign req_fire  = req_valid && imem_req_ready;
  // A response with nothing outstanding is spurious (e.g. issued before reset).
  assign resp_take = imem_resp_valid && (outstanding_q != '0);
  assign resp_keep = resp_take && (drop_q == '0) && !redirect_valid;
  assign pop       = (count_q != '0) && decode_ready && !redirect_valid;

  assign imem_req_valid    = req_valid;
  assign imem_req_addr     = fetch_pc_q;
  assign instruction_valid = (count_q != '0);
  assign instruction       = instruction_valid ? instr_mem_q[head_q] : '0;
  assign instruction_pc    = instruction_valid ? pc_mem_q[head_q] : '0;
  assign fetch_idle        = idle_q;

  // Next-state logic. RUN only falls into PAUSE once no request is left
  // waiting for acceptance, so a presented request is never withdrawn except
  // by a redirect.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_take);
    count_d       = count_q;
    drop_d        = drop_q;
    head_d        = head_q;
    tail_d        = tail_q;

    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (!fetch_enable && !(req_valid && !imem_req_ready)) state_d = PAUSE;
      PAUSE:   if (fetch_enable) state_d = RUN;
      default: state_d = BOOT;
    endcase

    if (redirect_valid) begin
      // Everything still in flight belongs to the wrong path.
      fetch_pc_d = redirect_target;
      resp_pc_d  = redirect_target;
      drop_d     = outstanding_q - CW'(resp_take);
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (resp_take && (drop_q != '0)) drop_d = drop_q - CW'(1);
      if (resp_keep) begin
        resp_pc_d = resp_pc_q + 32'd4;
        tail_d    = tail_q + AW'(1);
      end
      if (pop) head_d = head_q + AW'(1);
      count_d = count_q + CW'(resp_keep) - CW'(pop);
    end

    idle_d = (outstanding_d == '0) && (count_d == '0);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= BOOT;
      fetch_pc_q    <= {RESET_PC[31:2], 2'b00};
      resp_pc_q     <= {RESET_PC[31:2], 2'b00};
      outstanding_q <= '0;
      count_q       <= '0;
      drop_q        <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      idle_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      count_q       <= count_d;
      drop_q        <= drop_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      idle_q        <= idle_d;
    end
  end

  // Buffer storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (resp_keep) begin
      instr_mem_q[tail_q] <= imem_resp_data;
      pc_mem_q[tail_q]    <= resp_pc_q;
    end
  end

endmodule
